// File: rtl/axis_instr_assembler.sv
// rtl/axis_instr_assembler.sv - assembles tagged stream words into instruction packets
// Four tagged words form one packet; packets queue in a small first-word-fall-through FIFO.
module axis_instr_assembler #(
  parameter int DATA_WIDTH      = 128,
  parameter int WORDS_PER_INSTR = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_instr_tvalid,
  output logic                                  s_axis_instr_tready,
  input  logic [DATA_WIDTH-1:0]                 s_axis_instr_tdata,
  output logic                                  m_instr_valid,
  input  logic                                  m_instr_ready,
  output logic [DATA_WIDTH*WORDS_PER_INSTR-1:0] m_instr_data,
  output logic                                  m_instr_last,
  output logic [31:0]                           status
);

  localparam int PKT_W = DATA_WIDTH * WORDS_PER_INSTR;
  localparam int IDX_W = $clog2(WORDS_PER_INSTR);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_INSTR - 1);
  localparam logic [2:0] TAG_FIRST = 3'b100;

  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] slot [WORDS_PER_INSTR];
  logic [PKT_W-1:0]      mem  [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [15:0]           pkt_cnt;
  logic                  tag_err, done;

  logic [2:0]            tag, exp_tag;
  logic                  tag_ok, accept, push, pop, store;
  logic [IDX_W-1:0]      store_idx;
  logic                  fifo_empty, fifo_full;
  logic [PKT_W-1:0]      pkt_in;

  assign tag     = s_axis_instr_tdata[DATA_WIDTH-1:DATA_WIDTH-3];
  assign exp_tag = TAG_FIRST | 3'(idx);
  assign tag_ok  = (tag == exp_tag);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // The final word may enter a full FIFO only when the head leaves in the same cycle.
  assign s_axis_instr_tready = !rst && ((idx != LAST_IDX) || !fifo_full || m_instr_ready);
  assign accept = s_axis_instr_tvalid && s_axis_instr_tready;
  assign push   = accept && tag_ok && (idx == LAST_IDX);
  assign pop    = m_instr_valid && m_instr_ready;

  // A mis-tagged first-word tag restarts a packet instead of being dropped.
  assign store     = accept && (tag_ok || (tag == TAG_FIRST));
  assign store_idx = tag_ok ? idx : '0;

  always_ff @(posedge clk) begin
    if (rst) idx <= '0;
    else     idx <= idx_next;
  end

  always_comb begin
    idx_next = idx;
    if (accept) begin
      if (tag_ok)                 idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      else if (tag == TAG_FIRST)  idx_next = IDX_W'(1);
      else                        idx_next = '0;
    end
  end

  always_comb begin
    pkt_in = '0;
    for (int k = 0; k < WORDS_PER_INSTR - 1; k++)
      pkt_in[k*DATA_WIDTH +: DATA_WIDTH] = slot[k];
    pkt_in[PKT_W-1 -: DATA_WIDTH] = s_axis_instr_tdata;
  end

  always_ff @(posedge clk) begin
    if (store) slot[store_idx] <= s_axis_instr_tdata;
    if (push)  mem[wr_ptr[PTR_W-1:0]] <= pkt_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      tag_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (m_instr_last) done <= 1'b1;
      end
      if (accept && !tag_ok) tag_err <= 1'b1;
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  always_comb begin
    m_instr_valid = !fifo_empty;
    m_instr_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    m_instr_last  = m_instr_data[DATA_WIDTH-8];
    status        = {9'd0, 3'(idx), fifo_full, fifo_empty, done, tag_err, pkt_cnt};
  end

endmodule

// File: tb/tb_axis_instr_assembler.sv
// tb/tb_axis_instr_assembler.sv - directed vector bench for axis_instr_assembler
module tb_axis_instr_assembler;

  logic         clk;
  logic         rst;
  logic         tvalid;
  logic         tready;
  logic [127:0] tdata;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] m_data;
  logic         m_last;
  logic [31:0]  status;

  axis_instr_assembler dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_instr_tvalid (tvalid),
    .s_axis_instr_tready (tready),
    .s_axis_instr_tdata  (tdata),
    .m_instr_valid       (m_valid),
    .m_instr_ready       (m_ready),
    .m_instr_data        (m_data),
    .m_instr_last        (m_last),
    .status              (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] W0 = 128'h8000001b001b01010101002c0006000c;
  localparam logic [127:0] W1 = 128'ha0000000001b0ab2003b000e00003602;
  localparam logic [127:0] W2 = 128'hc00000000000049000000003200000c0;
  localparam logic [127:0] W3 = 128'he0000000782c000078280000780c0000;
  localparam logic [127:0] L0 = 128'h81000fc00240080702010d8005580c40;
  localparam logic [127:0] L1 = 128'ha0000000000000000000000000000011;
  localparam logic [127:0] L2 = 128'hc0000000000000000000000000000022;
  localparam logic [127:0] L3 = 128'he0000000000000000000000000000033;

  typedef struct {
    logic         tvalid;
    logic [127:0] tdata;
    logic         rdy;
    logic         exp_tready;
    logic         exp_valid;
    logic         exp_last;
    logic [31:0]  exp_status;
    logic [127:0] exp_lo;
    logic [127:0] exp_hi;
  } vec_t;

  vec_t vecs [10];
  int n_vec = 0;
  int n_bad = 0;
  int pops  = 0;
  logic mon_en = 1'b0;
  logic [511:0] exp_q [$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] pk(input logic [127:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] mkw(input int p, input int k);
    return {3'(4 + k), 93'd0, 32'(p * 16 + k)};
  endfunction

  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pop: got %0h expected none", m_data);
      end else begin
        chk("pop_data", m_data, exp_q[0]);
        chk("pop_last", m_last, exp_q[0][120]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; tdata = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pops = 0;
  endtask

  task automatic send_word(input logic [127:0] w);
    int n = 0;
    tvalid = 1'b1;
    tdata  = w;
    @(negedge clk);
    while (!tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tready) chk("send_timeout", tready, 1'b1);
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (m_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_done", m_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, W0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0014_0000, '0, '0};
    vecs[1] = '{1'b1, W1,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0024_0000, '0, '0};
    vecs[2] = '{1'b1, W2,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0034_0000, '0, '0};
    vecs[3] = '{1'b1, W3,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0001, W0, W3};
    vecs[4] = '{1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0004_0001, '0, '0};
    vecs[5] = '{1'b1, L0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0014_0001, '0, '0};
    vecs[6] = '{1'b1, L1,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0024_0001, '0, '0};
    vecs[7] = '{1'b1, L2,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0034_0001, '0, '0};
    vecs[8] = '{1'b1, L3,   1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0002, L0, L3};
    vecs[9] = '{1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0006_0002, '0, '0};

    // reset state
    do_reset();
    chk("rst_status", status, 32'h0004_0000);
    chk("rst_valid",  m_valid, 1'b0);
    chk("rst_last",   m_last, 1'b0);
    chk("rst_data",   m_data, '0);

    // table: assembly and last flag
    for (int i = 0; i < 10; i++) begin
      tvalid = vecs[i].tvalid;
      tdata  = vecs[i].tdata;
      m_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_tready", i), tready, vecs[i].exp_tready);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), m_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_last", i), m_last, vecs[i].exp_last);
      chk($sformatf("v%0d_status", i), status, vecs[i].exp_status);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_lo", i), m_data[127:0], vecs[i].exp_lo);
        chk($sformatf("v%0d_hi", i), m_data[511:384], vecs[i].exp_hi);
      end
    end
    tvalid = 1'b0;

    // backpressure, full, simultaneous push/pop at full
    do_reset();
    mon_en = 1'b1;
    for (int p = 0; p < 8; p++) exp_q.push_back(pk(mkw(p,0), mkw(p,1), mkw(p,2), mkw(p,3)));
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 4; k++) send_word(mkw(p, k));
    for (int k = 0; k < 3; k++) send_word(mkw(4, k));
    tvalid = 1'b1;
    tdata  = mkw(4, 3);
    @(negedge clk);
    chk("full_flag", status[19], 1'b1);
    chk("full_tready", tready, 1'b0);
    chk("full_count", status[15:0], 16'd4);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    chk("pushpop_tready", tready, 1'b1);
    @(posedge clk);
    #1 tvalid = 1'b0;
    m_ready = 1'b0;
    chk("pushpop_full", status[19], 1'b1);
    chk("pushpop_count", status[15:0], 16'd5);
    chk("pushpop_pops", 512'(pops), 512'd1);
    m_ready = 1'b1;
    for (int p = 5; p < 8; p++)
      for (int k = 0; k < 4; k++) send_word(mkw(p, k));
    drain();
    chk("bp_count", status[15:0], 16'd8);
    chk("bp_pops", 512'(pops), 512'd8);
    chk("bp_queue_empty", 512'(exp_q.size()), 512'd0);

    // tag error resync
    do_reset();
    m_ready = 1'b1;
    exp_q.push_back(pk(128'h80000000000000000000000000000002,
                       128'ha0000000000000000000000000000003,
                       128'hc0000000000000000000000000000004,
                       128'he0000000000000000000000000000005));
    send_word(128'h80000000000000000000000000000000);
    send_word(128'ha0000000000000000000000000000001);
    send_word(128'h80000000000000000000000000000002);
    chk("err_flag", status[16], 1'b1);
    chk("err_idx", status[22:20], 3'd1);
    send_word(128'ha0000000000000000000000000000003);
    send_word(128'hc0000000000000000000000000000004);
    send_word(128'he0000000000000000000000000000005);
    drain();
    chk("err_count", status[15:0], 16'd1);
    chk("err_pops", 512'(pops), 512'd1);
    chk("err_sticky", status[16], 1'b1);

    // reset mid-packet
    do_reset();
    m_ready = 1'b1;
    send_word(W0);
    send_word(W1);
    rst = 1'b1;
    tvalid = 1'b1;
    tdata = W2;
    @(negedge clk);
    chk("midrst_tready", tready, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_status", status, 32'h0004_0000);
    chk("midrst_valid", m_valid, 1'b0);
    rst = 1'b0;
    tvalid = 1'b0;
    pops = 0;
    exp_q.push_back(pk(W0, W1, W2, W3));
    send_word(W0);
    send_word(W1);
    send_word(W2);
    send_word(W3);
    drain();
    chk("midrst_after", status, 32'h0004_0001);
    chk("midrst_pops", 512'(pops), 512'd1);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
